// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states and 8N1 frame constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int unsigned DATA_BITS  = 8;
  localparam logic        STOP_LEVEL = 1'b1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; the head entry is presented on pop_data while not empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push_ok;
  logic             pop_ok;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  assign level = count;

  // A full FIFO still takes a write when the head is leaving in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to zero when empty so the output reads 0x00 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with mid-bit sampling, sticky error flags and a receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          RxD,
  output logic                          rd_valid,
  output logic [DATA_BITS-1:0]          rd_data,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t            state;
  rx_state_t            state_nxt;
  logic                 rx_sync1;
  logic                 rx_sync2;
  logic                 rx_prev;
  logic                 line;
  logic                 fall;
  logic [CW-1:0]        cnt;
  logic                 tick;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 byte_push;
  logic                 frame_event;
  logic                 data_shift;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_drop;

  // Two-flop synchronizer plus previous-value register for start-edge detection; idle-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync1 <= 1'b1;
      rx_sync2 <= 1'b1;
      rx_prev  <= 1'b1;
    end else begin
      rx_sync1 <= RxD;
      rx_sync2 <= rx_sync1;
      rx_prev  <= rx_sync2;
    end
  end

  assign line = rx_sync2;
  assign fall = rx_prev && !line;
  assign tick = (cnt == '0);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start detect, start-bit confirm, data bits, stop bit.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (fall) state_nxt = START;
      START: if (tick) state_nxt = (line == 1'b0) ? DATA : IDLE;
      DATA:  if (tick && (bit_idx == BW'(DATA_BITS - 1))) state_nxt = STOP;
      STOP:  if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: data-bit sample strobe and stop-bit outcome.
  always_comb begin
    data_shift  = 1'b0;
    byte_push   = 1'b0;
    frame_event = 1'b0;
    unique case (state)
      DATA: data_shift = tick;
      STOP: begin
        byte_push   = tick && (line == STOP_LEVEL);
        frame_event = tick && (line != STOP_LEVEL);
      end
      default: ;
    endcase
  end

  // Bit-time counter, data bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      if (state == IDLE) begin
        cnt     <= fall ? CNT_HALF : '0;
        bit_idx <= '0;
      end else begin
        cnt <= tick ? CNT_FULL : cnt - CW'(1);
      end
      if (data_shift) begin
        shreg   <= {line, shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
    end
  end

  // A full FIFO is never empty, so rd_ready alone means the head is leaving this cycle.
  assign fifo_drop = byte_push && fifo_full && !rd_ready;

  // Sticky error flags; a new error in the clear cycle wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (frame_event) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
      if (fifo_drop) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (byte_push),
    .push_data (shreg),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign rd_valid = !fifo_empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=16.
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       RxD;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       rd_ready;
  logic [4:0] level;
  logic       frame_err;
  logic       overrun;
  logic       err_clr;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] exp_q [$];
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .RxD       (RxD),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_ready  (rd_ready),
    .level     (level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .err_clr   (err_clr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted byte is compared against the oldest expected byte.
  always @(negedge clk) begin
    if (!rst && rd_valid && rd_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_pop: got %0h required no byte", rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rd_data !== mon_exp) begin
          bad++;
          $display("FAIL sb_pop: got %0h required %0h", rd_data, mon_exp);
        end
      end
    end
  end

  // Frame starts one cycle after the call; returns #1 after the edge preceding the stop-sample push edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop_at_stop);
    @(posedge clk); #1; RxD = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge clk);
      #1; RxD = b[i];
    end
    repeat (CPB) @(posedge clk);
    #1; RxD = stop;
    repeat (CPB) @(posedge clk);
    #1; RxD = 1'b1;
    if (pop_at_stop) begin
      rd_ready = 1'b1;
      @(posedge clk); #1;
      rd_ready = 1'b0;
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    rd_ready = 1'b1;
    while (rd_valid && n < 64) begin
      cycles(1);
      n++;
    end
    rd_ready = 1'b0;
    check("drain_done", rd_valid, 1'b0);
    check("drain_level", level, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    rst = 1'b1; RxD = 1'b1; rd_ready = 1'b0; err_clr = 1'b0;
    cycles(3);
    check("rst_valid", rd_valid, 1'b0);
    check("rst_level", level, 0);
    check("rst_data", rd_data, 8'h00);
    check("rst_ferr", frame_err, 1'b0);
    check("rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    cycles(5);

    // Single frame, first-word-fall-through timing, then pop.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_valid_before", rd_valid, 1'b0);
    cycles(1);
    check("a5_valid", rd_valid, 1'b1);
    check("a5_data", rd_data, 8'hA5);
    check("a5_level", level, 1);
    rd_ready = 1'b1;
    cycles(1);
    rd_ready = 1'b0;
    check("a5_pop_level", level, 0);
    check("a5_pop_valid", rd_valid, 1'b0);

    // One-clock glitch on the line.
    RxD = 1'b0;
    cycles(1);
    RxD = 1'b1;
    cycles(12);
    check("glitch_level", level, 0);
    check("glitch_ferr", frame_err, 1'b0);
    check("glitch_ovr", overrun, 1'b0);
    check("glitch_valid", rd_valid, 1'b0);

    // Bad stop bit.
    send_frame(8'h3C, 1'b0, 1'b0);
    cycles(2);
    check("ferr_set", frame_err, 1'b1);
    check("ferr_level", level, 0);
    pulse_clr();
    check("ferr_clr", frame_err, 1'b0);

    // Fill, then overflow with 0xFF.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    cycles(1);
    check("fill_level", level, 16);
    send_frame(8'hFF, 1'b1, 1'b0);
    cycles(1);
    check("ovr_level", level, 16);
    check("ovr_set", overrun, 1'b1);
    pulse_clr();
    check("ovr_clr", overrun, 1'b0);
    drain();

    // Full FIFO with pop coinciding with push of 0x77.
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h80 + 8'(i));
      send_frame(8'h80 + 8'(i), 1'b1, 1'b0);
    end
    cycles(1);
    check("full2_level", level, 16);
    exp_q.push_back(8'h77);
    send_frame(8'h77, 1'b1, 1'b1);
    check("coinc_level", level, 16);
    check("coinc_ovr", overrun, 1'b0);
    drain();
    check("coinc_sb_empty", exp_q.size(), 0);

    // Reset in the middle of data bit 3 with a stored byte and a set flag.
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0);
    cycles(2);
    check("pre_rst_level", level, 1);
    check("pre_rst_ferr", frame_err, 1'b1);
    b = 8'h5A;
    @(posedge clk); #1; RxD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      repeat (CPB) @(posedge clk);
      #1; RxD = b[i];
    end
    cycles(2);
    rst = 1'b1;
    exp_q.delete();
    RxD = 1'b1;
    cycles(2);
    check("mid_rst_valid", rd_valid, 1'b0);
    check("mid_rst_level", level, 0);
    check("mid_rst_data", rd_data, 8'h00);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_ovr", overrun, 1'b0);
    rst = 1'b0;
    cycles(20);
    check("post_rst_level", level, 0);
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    cycles(1);
    check("post_rst_55_level", level, 1);
    check("post_rst_55_data", rd_data, 8'h55);
    drain();

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, giving clocks per serial bit (100 MHz / 115200); legal range >= 4.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, giving receive FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock for all logic.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port RxD  input  1  asynchronous serial line, idle high, 8N1 format.
REQ-006 SHALL have port rd_valid  output  1  FIFO holds at least one byte.
REQ-007 SHALL have port rd_data  output  8  oldest byte in FIFO, valid while rd_valid=1.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-009 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-010 SHALL have port frame_err  output  1  sticky flag: stop bit sampled low.
REQ-011 SHALL have port overrun  output  1  sticky flag: byte dropped because the FIFO was full.
REQ-012 SHALL have port err_clr  input  1  single-cycle clear of frame_err and overrun.

Function
REQ-013 SHALL pass RxD through a two-flop synchronizer; all sampling uses the synchronized value.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: SHALL enter START only on a synchronized 1->0 transition, loading the bit counter with CLKS_PER_BIT/2-1.
REQ-016 START: at counter zero, SHALL go to DATA (counter reloaded to CLKS_PER_BIT-1) if the line is 0; otherwise SHALL return to IDLE (glitch reject).
REQ-017 DATA: SHALL sample 8 bits at successive counter-zero points, LSB first, then go to STOP.
REQ-018 STOP: at counter zero, if the line is 1, SHALL push the byte and return to IDLE; if the line is 0, SHALL set frame_err, discard the byte and return to IDLE.
REQ-019 SHALL push the byte on the stop-sample edge; rd_valid SHALL rise on the following cycle (first-word-fall-through).
REQ-020 SHALL pop when rd_valid && rd_ready; rd_ready with an empty FIFO SHALL have no effect.
REQ-021 A push into a full FIFO without a simultaneous pop SHALL drop the byte and set overrun; level stays FIFO_DEPTH.
REQ-022 A push and a pop in the same cycle on a full FIFO SHALL accept both, leave level unchanged, and not set overrun.
REQ-023 A push and a pop in the same cycle on an empty FIFO SHALL leave level at 1 after the cycle.
REQ-024 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level SHALL equal the number of stored bytes, 0..FIFO_DEPTH.
REQ-025 err_clr SHALL clear both flags; an error event in the same cycle SHALL take precedence, leaving that flag set.

Reset
REQ-026 rst SHALL force: FSM=IDLE, counters=0, FIFO empty, rd_valid=0, level=0, frame_err=0, overrun=0, rd_data=0x00.
REQ-027 Synchronizer flops and the previous-line register SHALL reset to 1, so reset with RxD held low does not start a frame.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no push; reception SHALL resume on the next 1->0 transition after release.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state enum and the frame constants (DATA_BITS=8, stop-bit level).
REQ-030 The FIFO SHALL be a separate sub-module sync_fifo (parameterized width/depth, push/pop, full/empty/level); the FSM, synchronizer and flags SHALL sit in uart_rx_fifo.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=16)
REQ-031 Drive frame 0xA5 -> rd_valid=1 one cycle after the stop sample, rd_data=0xA5, level=1; pop -> level=0, rd_valid=0.
REQ-032 Pulse RxD low for 1 clock -> FSM returns to IDLE from START, no push, level=0, no flags.
REQ-033 Drive 0x3C with stop bit 0 -> frame_err=1, level=0; err_clr -> frame_err=0.
REQ-034 Send bytes 0x00..0x0F without popping, then 0xFF -> level=16, overrun=1; drain yields 0x00..0x0F in order.
REQ-035 Full FIFO, rd_ready held so the pop coincides with the push of 0x77 -> level stays 16, overrun=0, 0x77 is the last byte read.
REQ-036 Assert rst during bit 3 of a frame -> all outputs reset per REQ-026; next frame 0x55 is received correctly with level=1.
